adder_seq_ctrl: RTL

//  Sequencer that runs an NBYTES-wide add/subtract through a single shared adder_8bit

---
 rtl/adder_seq_ctrl_if.sv | 26 ++
 rtl/adder_seq_ctrl.sv | 114 +++++++++++
 2 files changed

// File: rtl/adder_seq_ctrl_if.sv
// rtl/adder_seq_ctrl_if.sv - request/result bundle for the byte-serial add/subtract sequencer
interface adder_seq_ctrl_if #(
  parameter int NBYTES = 4
);
  localparam int W = 8 * NBYTES;

  logic         Start;
  logic         Sub;
  logic [W-1:0] A;
  logic [W-1:0] B;
  logic         Busy;
  logic         Done;
  logic [W-1:0] Sum;
  logic         Cout;
  logic         Overflow;

  modport master (
    output Start, Sub, A, B,
    input  Busy, Done, Sum, Cout, Overflow
  );

  modport slave (
    input  Start, Sub, A, B,
    output Busy, Done, Sum, Cout, Overflow
  );
endinterface

// File: rtl/adder_seq_ctrl.sv
// rtl/adder_seq_ctrl.sv - multi-precision add/subtract sequenced one byte per cycle through one 8-bit adder
// Operands latch on an accepted Start; result and flags update only on DONE entry.
module adder_8bit (
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic       cin,
  output logic [7:0] sum,
  output logic       cout
);
  assign {cout, sum} = {1'b0, a} + {1'b0, b} + {8'd0, cin};
endmodule

module adder_seq_ctrl #(
  parameter int NBYTES = 4
) (
  input  logic             clk,
  input  logic             reset,
  adder_seq_ctrl_if.slave  bus
);
  localparam int W  = 8 * NBYTES;
  localparam int IW = (NBYTES > 1) ? $clog2(NBYTES) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t        state, state_next;
  logic [W-1:0]  sa, sb, sr, sr_next;
  logic [W-1:0]  sum_q;
  logic          c, cout_q, ovf_q;
  logic [IW-1:0] idx;
  logic          busy, done, accept, last;
  logic [7:0]    add_sum;
  logic          add_cout;

  adder_8bit u_add (
    .a    (sa[7:0]),
    .b    (sb[7:0]),
    .cin  (c),
    .sum  (add_sum),
    .cout (add_cout)
  );

  assign last = (idx == IW'(NBYTES - 1));
  // New byte enters at the top so byte 0 ends up in [7:0] after NBYTES shifts.
  assign sr_next = (sr >> 8) | (W'(add_sum) << (W - 8));

  always_comb begin
    state_next = state;
    busy       = 1'b0;
    done       = 1'b0;
    accept     = 1'b0;
    case (state)
      IDLE: begin
        if (bus.Start) begin
          accept     = 1'b1;
          state_next = RUN;
        end
      end
      RUN: begin
        busy = 1'b1;
        if (last) state_next = DONE;
      end
      DONE: begin
        done = 1'b1;
        if (bus.Start) begin
          accept     = 1'b1;
          state_next = RUN;
        end else begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      sa     <= '0;
      sb     <= '0;
      sr     <= '0;
      c      <= 1'b0;
      idx    <= '0;
      sum_q  <= '0;
      cout_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      state <= state_next;
      if (accept) begin
        // Subtract as A + ~B + 1: the +1 rides in on the initial carry.
        sa  <= bus.A;
        sb  <= bus.Sub ? ~bus.B : bus.B;
        c   <= bus.Sub;
        idx <= '0;
      end else if (busy) begin
        sa  <= sa >> 8;
        sb  <= sb >> 8;
        sr  <= sr_next;
        c   <= add_cout;
        idx <= idx + 1'b1;
        if (last) begin
          sum_q  <= sr_next;
          cout_q <= add_cout;
          ovf_q  <= (sa[7] == sb[7]) && (add_sum[7] != sa[7]);
        end
      end
    end
  end

  assign bus.Busy     = busy;
  assign bus.Done     = done;
  assign bus.Sum      = sum_q;
  assign bus.Cout     = cout_q;
  assign bus.Overflow = ovf_q;
endmodule
